md_unit: RTL and testbench

- Multi-cycle multiply/divide unit with architectural HI/LO registers. Sits in the EX stage beside the ALU.
- Executes MULT/MULTU/DIV/DIVU with parametrised latency and handles MTHI/MTLO in one cycle.
- Exposes `busy` so the hazard/stall logic can hold D-stage instructions that touch the unit (mult/div/mfhi/mflo/mthi/mtlo).
- It is the first EX-stage block with its own state; the pipeline enable `en` is no longer constant 1.

---
 rtl/md_defs.sv | 25 ++
 rtl/md_unit_if.sv | 17 +
 rtl/md_unit_arith.sv | 62 ++++++
 rtl/md_unit.sv | 100 ++++++++++
 tb/tb_md_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/md_defs.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states,
// and the counter-width helper.
package md_defs;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   // Wide enough to hold the longer of the two latencies.
   function automatic int cnt_width(input int mult_cycles, input int div_cycles);
      return $clog2(((mult_cycles > div_cycles) ? mult_cycles : div_cycles) + 1);
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage request/result bundle between the controller/datapath and md_unit.
interface md_unit_if
   import md_defs::*;
#(
   parameter int WIDTH = 32
);
   logic             start;
   md_op_e           md_op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, md_op, A, B, input busy, hi, lo);
   modport slave  (input start, md_op, A, B, output busy, hi, lo);
endinterface

// File: rtl/md_unit_arith.sv
// Combinational multiply/divide datapath; the result is latched by md_unit
// at issue and committed after the modelled latency.
module md_arith
   import md_defs::*;
#(
   parameter int WIDTH = 32
) (
   input  md_op_e           md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div_by_zero
);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [2*WIDTH-1:0]        uprod;
   logic signed [2*WIDTH-1:0] sprod;
   logic [WIDTH-1:0]          b_safe;
   logic signed [WIDTH-1:0]   sq, sr;
   logic [WIDTH-1:0]          uq, ur;
   logic                      b_zero, s_ovf;

   assign b_zero = (b == '0);
   assign s_ovf  = (a == MOST_NEG) && (b == '1);
   // Divisor forced nonzero so the dividers never see x/0; the result is dropped anyway.
   assign b_safe = b_zero ? ONE : b;

   assign uprod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign sprod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
   assign sq    = $signed(a) / $signed(b_safe);
   assign sr    = $signed(a) % $signed(b_safe);
   assign uq    = a / b_safe;
   assign ur    = a % b_safe;

   always_comb begin
      res_hi      = '0;
      res_lo      = '0;
      div_by_zero = 1'b0;
      case (md_op)
         MD_MULT:  {res_hi, res_lo} = sprod;
         MD_MULTU: {res_hi, res_lo} = uprod;
         MD_DIV: begin
            div_by_zero = b_zero;
            if (s_ovf) begin
               res_hi = '0;
               res_lo = MOST_NEG;
            end else begin
               res_hi = sr;
               res_lo = sq;
            end
         end
         MD_DIVU: begin
            div_by_zero = b_zero;
            res_hi      = ur;
            res_lo      = uq;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit with architectural HI/LO. busy covers the whole
// latency so hazard logic can stall any instruction touching HI/LO.
module md_unit
   import md_defs::*;
#(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic     clk,
   input  logic     reset,
   md_unit_if.slave md
);
   localparam int            CW     = cnt_width(MULT_CYCLES, DIV_CYCLES);
   localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_1  = CW'(1);

   md_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic             pend_dbz_q, pend_dbz_d;

   logic [WIDTH-1:0] ar_hi, ar_lo;
   logic             ar_dbz;

   md_arith #(.WIDTH(WIDTH)) u_arith (
      .md_op       (md.md_op),
      .a           (md.A),
      .b           (md.B),
      .res_hi      (ar_hi),
      .res_lo      (ar_lo),
      .div_by_zero (ar_dbz)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      pend_hi_d  = pend_hi_q;
      pend_lo_d  = pend_lo_q;
      pend_dbz_d = pend_dbz_q;
      case (state_q)
         IDLE: begin
            if (md.start) begin
               case (md.md_op)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     state_d    = RUN;
                     cnt_d      = (md.md_op == MD_MULT || md.md_op == MD_MULTU) ? MULT_N : DIV_N;
                     pend_hi_d  = ar_hi;
                     pend_lo_d  = ar_lo;
                     pend_dbz_d = ar_dbz;
                  end
                  MD_MTHI: hi_d = md.A;
                  MD_MTLO: lo_d = md.A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            // Requests arriving here are ignored; the stall logic keeps them out.
            cnt_d = cnt_q - CNT_1;
            if (cnt_q == CNT_1) begin
               state_d = IDLE;
               if (!pend_dbz_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         pend_hi_q  <= '0;
         pend_lo_q  <= '0;
         pend_dbz_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         pend_hi_q  <= pend_hi_d;
         pend_lo_q  <= pend_lo_d;
         pend_dbz_q <= pend_dbz_d;
      end
   end

   assign md.busy = (state_q == RUN);
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: stimulus queues expected completions, a monitor
// checks each busy window (length, HI/LO hold) and the committed result.
module tb_md_unit;
   import md_defs::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp_t sb[$];

   md_unit_if #(.WIDTH(32)) mif ();

   md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      mif.start = 1'b1;
      mif.md_op = op;
      mif.A     = a;
      mif.B     = b;
      @(negedge clk);
      mif.start = 1'b0;
      mif.md_op = MD_NONE;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (mif.busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", {31'd0, mif.busy}, 32'd0);
      @(negedge clk);
   endtask

   // Monitor: a busy window ending is the unit's "result valid".
   logic        prev_busy = 1'b0;
   logic        moved     = 1'b0;
   logic [31:0] hold_hi, hold_lo;
   int          blen = 0;
   always @(negedge clk) begin
      exp_t e;
      if (mif.busy) begin
         if (!prev_busy) begin
            blen    = 1;
            hold_hi = mif.hi;
            hold_lo = mif.lo;
            moved   = 1'b0;
         end else begin
            blen++;
            if (mif.hi !== hold_hi || mif.lo !== hold_lo) moved = 1'b1;
         end
      end else if (prev_busy) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got completion want none");
         end else begin
            e = sb.pop_front();
            chk("done_hi", mif.hi, e.hi);
            chk("done_lo", mif.lo, e.lo);
            chk("busy_len", blen, e.len);
            chk("hold_in_run", {31'd0, moved}, 32'd0);
         end
      end
      prev_busy = mif.busy;
   end

   initial begin
      mif.start = 1'b0;
      mif.md_op = MD_NONE;
      mif.A     = '0;
      mif.B     = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, mif.busy}, 32'd0);
      chk("rst_hi", mif.hi, 32'd0);
      chk("rst_lo", mif.lo, 32'd0);
      reset = 1'b1;

      sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFA, 5});
      issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
      wait_idle();

      sb.push_back('{32'hFFFFFFFE, 32'h00000001, 5});
      issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle();

      sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD, 10});
      issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
      wait_idle();

      sb.push_back('{32'd1, 32'd3, 10});
      issue(MD_DIVU, 32'd7, 32'd2);
      wait_idle();

      // Back-to-back MTHI / MTLO.
      @(negedge clk);
      mif.start = 1'b1;
      mif.md_op = MD_MTHI;
      mif.A     = 32'h12345678;
      @(negedge clk);
      chk("mthi_hi", mif.hi, 32'h12345678);
      chk("mthi_lo_kept", mif.lo, 32'd3);
      chk("mthi_busy", {31'd0, mif.busy}, 32'd0);
      mif.md_op = MD_MTLO;
      mif.A     = 32'h9ABCDEF0;
      @(negedge clk);
      mif.start = 1'b0;
      mif.md_op = MD_NONE;
      chk("mtlo_lo", mif.lo, 32'h9ABCDEF0);
      chk("mtlo_hi_kept", mif.hi, 32'h12345678);
      chk("mtlo_busy", {31'd0, mif.busy}, 32'd0);

      // Divide by zero keeps preloaded HI/LO.
      issue(MD_MTHI, 32'd5, 32'd0);
      issue(MD_MTLO, 32'd6, 32'd0);
      sb.push_back('{32'd5, 32'd6, 10});
      issue(MD_DIV, 32'd1, 32'd0);
      wait_idle();

      sb.push_back('{32'd0, 32'h80000000, 10});
      issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
      wait_idle();

      // NONE and an undefined opcode do nothing.
      issue(MD_NONE, 32'd77, 32'd1);
      issue(md_op_e'(3'd7), 32'd88, 32'd1);
      chk("nop_busy", {31'd0, mif.busy}, 32'd0);
      chk("nop_hi", mif.hi, 32'd0);
      chk("nop_lo", mif.lo, 32'h80000000);

      // Reset on the third busy cycle aborts the multiply.
      sb.push_back('{32'd0, 32'd0, 3});
      issue(MD_MULT, 32'd3, 32'd4);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort_busy", {31'd0, mif.busy}, 32'd0);
      chk("abort_hi", mif.hi, 32'd0);
      chk("abort_lo", mif.lo, 32'd0);
      repeat (8) @(negedge clk);
      chk("abort_late_hi", mif.hi, 32'd0);
      chk("abort_late_lo", mif.lo, 32'd0);

      // A start during RUN must not disturb the first result.
      sb.push_back('{32'd0, 32'd12, 5});
      issue(MD_MULT, 32'd3, 32'd4);
      mif.start = 1'b1;
      mif.md_op = MD_DIVU;
      mif.A     = 32'd100;
      mif.B     = 32'd7;
      @(negedge clk);
      mif.start = 1'b0;
      mif.md_op = MD_NONE;
      wait_idle();
      repeat (12) @(negedge clk);
      chk("overlap_hi", mif.hi, 32'd0);
      chk("overlap_lo", mif.lo, 32'd12);
      chk("overlap_busy", {31'd0, mif.busy}, 32'd0);

      chk("sb_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
